// File: rtl/csa_mult_sequencer.sv
// Iterative N x N unsigned multiplier: two partial products per cycle are folded
// into sum/carry registers through a 4:2 compressor, then resolved by one CPA.

module adder4_2comp (
  input  logic [31:0] A1,
  input  logic [31:0] A2,
  input  logic [31:0] A3,
  input  logic [31:0] A4,
  output logic [31:0] S1,
  output logic [31:0] S2
);
  logic [31:0] w_t;
  logic [31:0] w_c1;

  // Two chained 3:2 stages; carries out of bit 31 are dropped (mod 2^32).
  assign w_t  = A1 ^ A2 ^ A3;
  assign w_c1 = ((A1 & A2) | (A1 & A3) | (A2 & A3)) << 1;
  assign S1   = w_t ^ w_c1 ^ A4;
  assign S2   = ((w_t & w_c1) | (w_t & A4) | (w_c1 & A4)) << 1;
endmodule

module csa_mult_sequencer #(
  parameter int unsigned N          = 16,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] P,
  output logic           busy
);
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, COMPRESS, RESOLVE, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [31:0]     r_sum;
  logic [31:0]     r_carry;
  logic [CW-1:0]   r_cnt;
  logic [2*N-1:0]  r_p;

  logic [31:0]     w_sh;
  logic [1:0]      w_bpair;
  logic [N-1:0]    w_rem;
  logic [31:0]     w_aext;
  logic [31:0]     w_pp0;
  logic [31:0]     w_pp1;
  logic [31:0]     w_s1;
  logic [31:0]     w_s2;
  logic [31:0]     w_total;
  logic            w_last;
  logic            w_stop;

  assign w_sh    = 32'(r_cnt) << 1;
  assign w_bpair = 2'(r_b >> w_sh);
  // Shifting past N yields zero, so the empty slice on the last pair reads as zero.
  assign w_rem   = r_b >> (w_sh + 32'd2);
  assign w_aext  = 32'(r_a);
  assign w_pp0   = w_bpair[0] ? (w_aext << w_sh) : '0;
  assign w_pp1   = w_bpair[1] ? (w_aext << (w_sh + 32'd1)) : '0;
  assign w_last  = (r_cnt == CW'(N/2 - 1));
  assign w_stop  = w_last || ((EARLY_EXIT != 0) && (w_rem == '0));
  assign w_total = r_sum + r_carry;

  adder4_2comp u_comp (
    .A1 (r_sum),
    .A2 (r_carry),
    .A3 (w_pp0),
    .A4 (w_pp1),
    .S1 (w_s1),
    .S2 (w_s2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (in_valid) w_next = COMPRESS;
      COMPRESS: if (w_stop)   w_next = RESOLVE;
      RESOLVE:                w_next = DONE;
      DONE:     if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE) && !rst;
    out_valid = (r_state == DONE);
    busy      = (r_state == COMPRESS) || (r_state == RESOLVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= A;
          r_b     <= B;
          r_sum   <= '0;
          r_carry <= '0;
          r_cnt   <= '0;
        end
        COMPRESS: begin
          r_sum   <= w_s1;
          r_carry <= w_s2;
          r_cnt   <= r_cnt + CW'(1);
        end
        RESOLVE: r_p <= w_total[2*N-1:0];
        default: ;
      endcase
    end
  end

  assign P = r_p;
endmodule

// File: tb/tb_csa_mult_sequencer.sv
// Directed and randomized checks of csa_mult_sequencer with and without early exit.

module tb_csa_mult_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;

  logic        rdy0, ov0, busy0;
  logic        rdy1, ov1, busy1;
  logic [31:0] p0, p1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  csa_mult_sequencer #(.N(16), .EARLY_EXIT(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .A(A), .B(B),
    .out_valid(ov0), .out_ready(out_ready), .P(p0), .busy(busy0)
  );

  csa_mult_sequencer #(.N(16), .EARLY_EXIT(0)) u_dut_ne (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .A(A), .B(B),
    .out_valid(ov1), .out_ready(out_ready), .P(p1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned model_compress(input logic [15:0] b);
    int unsigned c = 1;
    while (c < 8 && (b >> (2 * c)) != 0) c++;
    return c;
  endfunction

  // One transaction on both DUTs; exp_lat is the early-exit latency, the other is always 9.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_p,
                       input int unsigned exp_lat, input int unsigned stall,
                       input bit hold, input logic [15:0] ha, input logic [15:0] hb);
    int unsigned lat0 = 0, lat1 = 0, bcnt = 0;
    bit s0 = 0, s1 = 0;
    chk("in_ready_idle", {63'd0, rdy0}, 64'd1);
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; A = 16'($urandom); B = 16'($urandom);
    if (busy0) bcnt++;
    for (int unsigned t = 1; t <= 20 && !(s0 && s1); t++) begin
      @(posedge clk); #1;
      if (ov0 && !s0) begin s0 = 1; lat0 = t; end
      else if (!s0 && busy0) bcnt++;
      if (ov1 && !s1) begin s1 = 1; lat1 = t; end
    end
    chk("lat_ee", 64'(lat0), 64'(exp_lat));
    chk("lat_noee", 64'(lat1), 64'd9);
    chk("busy_cycles", 64'(bcnt), 64'(exp_lat));
    chk("p_ee", 64'(p0), 64'(exp_p));
    chk("p_noee", 64'(p1), 64'(exp_p));
    for (int unsigned i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1)); A = 16'($urandom); B = 16'($urandom);
      @(posedge clk); #1;
      chk("stall_valid", {63'd0, ov0}, 64'd1);
      chk("stall_p", 64'(p0), 64'(exp_p));
      chk("stall_in_ready", {63'd0, rdy0}, 64'd0);
    end
    out_ready = 1'b1; in_valid = hold; A = ha; B = hb;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (!hold) in_valid = 1'b0;
    chk("hs_valid_ee", {63'd0, ov0}, 64'd0);
    chk("hs_valid_noee", {63'd0, ov1}, 64'd0);
    chk("hs_busy", {63'd0, busy0}, 64'd0);
    chk("hs_p_kept", 64'(p0), 64'(exp_p));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {63'd0, ov0}, 64'd0);
    chk("rst_p", 64'(p0), 64'd0);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", {63'd0, rdy0}, 64'd1);

    do_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 9, 0, 0, '0, '0);
    do_op(16'h0003, 16'h0005, 32'd15, 3, 0, 0, '0, '0);
    do_op(16'h1234, 16'h0000, 32'd0, 2, 0, 0, '0, '0);
    do_op(16'h0000, 16'h8001, 32'd0, 9, 0, 0, '0, '0);
    // Second request held during backpressure must be taken only after returning to IDLE.
    do_op(16'h00A5, 16'h0F0F, 32'h0009B4AB, 7, 5, 1, 16'h1234, 16'h5678);
    do_op(16'h1234, 16'h5678, 32'h06260060, 9, 0, 0, '0, '0);

    A = 16'hFFFF; B = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #4 rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, ov0}, 64'd0);
    chk("arst_p", 64'(p0), 64'd0);
    chk("arst_busy", {63'd0, busy0}, 64'd0);
    chk("arst_busy_noee", {63'd0, busy1}, 64'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_in_ready", {63'd0, rdy0}, 64'd1);
    do_op(16'h00FF, 16'h0100, 32'h0000FF00, 6, 0, 0, '0, '0);

    for (int unsigned k = 0; k < 2000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 15);
      do_op(ra, rb, 32'(ra) * 32'(rb), model_compress(rb) + 1,
            $urandom_range(0, 3), 0, '0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/csa_mult_sequencer.md
Name: csa_mult_sequencer

Overview:
- Iterative N x N unsigned multiplier controller built around the team's 32-bit 4:2 compressor (adder4_2comp).
- Each cycle it generates two shifted partial products from the latched operands and folds them into registered sum/carry accumulators. A final carry-propagate add produces the product.
- Area-reduced alternative to the full Dadda tree; uses a valid/ready handshake on both sides.

Parameters:
- N, 16, operand width. Must be even, with 2N <= 32; the product width is 2N.
- EARLY_EXIT, 1, when 1 the block stops compressing once the remaining multiplier bits are all zero.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- A  input  N  multiplicand, unsigned.
- B  input  N  multiplier, unsigned.
- out_valid  output  1  P is valid; held until accepted.
- out_ready  input  1  consumer accepts P.
- P  output  2N  product A*B.
- busy  output  1  high in COMPRESS or RESOLVE.

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE, cnt=0.
  - sum, carry, latched A/B, P = 0.
  - out_valid=0, busy=0, in_ready=1 once rst is deasserted.
- Reset mid-operation aborts immediately. No output is produced and the operands are discarded.
- Compressor contract: S1+S2 == A1+A2+A3+A4 mod 2^32. The block relies only on this invariant, never on the internal S2 alignment.
- Wiring: A1=sum, A2=carry, A3=PP(2*cnt), A4=PP(2*cnt+1).
- Partial product: PP(i) = B_lat[i] ? (zero-extend A_lat) << i : 0, 32-bit.
- FSM states: IDLE, COMPRESS, RESOLVE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch A, B; clear sum, carry, cnt; go to COMPRESS.
- COMPRESS:
  - Each edge: sum<=S1, carry<=S2, cnt<=cnt+1.
  - Go to RESOLVE when cnt==N/2-1, or when EARLY_EXIT=1 and B_lat[N-1:2*cnt+2]==0. On the last pair the slice is empty and treated as zero.
  - Otherwise stay in COMPRESS.
  - At least one COMPRESS cycle always occurs, including when B=0.
- RESOLVE:
  - One cycle: P <= (sum+carry)[2N-1:0], out_valid<=1, go to DONE.
- DONE:
  - out_valid=1, P held stable.
  - On out_ready: out_valid<=0, go to IDLE. P keeps its last value.
- Handshake rules:
  - in_valid while not IDLE is ignored and not queued.
  - New operands are never accepted in the same cycle as the output handshake; the earliest next accept is the cycle after returning to IDLE.
  - A and B may change freely after the accept edge.
- Latency, counted from the accept edge to the edge that raises out_valid: C+1 edges, where C is the number of COMPRESS cycles.
  - Maximum: N/2+1, i.e. 9 for N=16.
  - Minimum: 2.
- Width rule: all accumulation is mod 2^32. For N=16 the true product fits, so there is no overflow.
- busy=1 exactly in COMPRESS and RESOLVE.

Test Plan:
- Full-range case: reset, then A=16'hFFFF, B=16'hFFFF. Required: out_valid rises 9 edges after accept, P=32'hFFFE0001, busy high for 9 cycles.
- Early exit (EARLY_EXIT=1): A=3, B=5. Required: 2 COMPRESS cycles, out_valid 3 edges after accept, P=15. The same case with EARLY_EXIT=0 gives 9 edges, P=15.
- Zero operands: B=0 and A=16'h1234. Required: 1 COMPRESS cycle, P=0 at 2 edges. Separately, A=0 and B=16'h8001: P=0, full 9 edges because B[15] is set.
- Backpressure and ignored input: hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with new operands. Required: P stays stable, in_ready=0, the second request is not taken. Then pulse out_ready: the next accept occurs exactly one cycle later in IDLE.
- Async reset mid-operation: assert rst between clock edges during COMPRESS cycle 3. Required: out_valid=0 and P=0 immediately, state IDLE. A subsequent A=16'h00FF, B=16'h0100 yields P=32'h0000FF00.
- Random regression: 2000 random A/B pairs with random out_ready stalls, compared against a reference model of A*B and the latency formula.
